// File: rtl/newton_step_multiply.sv
// Newton-Raphson refinement multiply y1 = y0 * (1.5 - x/2*y0^2): 3-stage pipelined fp32 multiplier.
// Define NEWTON_MUL_ROUND_NEAREST_EN for round-to-nearest-even in stage 3 (default: truncation).
module newton_step_multiply #(
  parameter int STAGES   = 3,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] NumA,
  input  logic [31:0] Init,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] NumOut,
  output logic [1:0]  flags
);

  if (STAGES != 3) begin : g_bad_stages
    $error("newton_step_multiply: STAGES must be 3");
  end

  logic adv;

  logic        v1, s1_sign, s1_zero;
  logic [9:0]  s1_esum;
  logic [23:0] s1_ma, s1_mb;

  logic        v2, s2_sign, s2_zero;
  logic [9:0]  s2_esum;
  logic [47:0] s2_p;

  logic [9:0] esum_in;
  logic       zero_in;

  // Bubbles move with the pipe; only a full stage 3 with a stalled consumer blocks it.
  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv;

  assign esum_in = {2'b00, NumA[30:23]} + {2'b00, Init[30:23]} - 10'(EXP_BIAS);
  assign zero_in = (NumA[30:23] == 8'd0) | (Init[30:23] == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_esum <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
    end else if (adv) begin
      v1      <= in_valid & in_ready;
      s1_sign <= NumA[31] ^ Init[31];
      s1_zero <= zero_in;
      s1_esum <= esum_in;
      s1_ma   <= {1'b1, NumA[22:0]};
      s1_mb   <= {1'b1, Init[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_esum <= '0;
      s2_p    <= '0;
    end else if (adv) begin
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_esum <= s1_esum;
      s2_p    <= s1_ma * s1_mb;
    end
  end

  logic               norm_hi;
  logic [23:0]        m24;
  logic signed [10:0] exp_n;
  logic signed [10:0] exp_f;
  logic [22:0]        frac;
  logic [31:0]        res_num;
  logic [1:0]         res_flags;

  assign norm_hi = s2_p[47];
  assign m24     = norm_hi ? s2_p[47:24] : s2_p[46:23];
  assign exp_n   = {s2_esum[9], s2_esum} + {10'd0, norm_hi};

`ifdef NEWTON_MUL_ROUND_NEAREST_EN
  logic        guard, sticky, round_up;
  logic [24:0] m25;

  assign guard    = norm_hi ? s2_p[23] : s2_p[22];
  assign sticky   = norm_hi ? (|s2_p[22:0]) : (|s2_p[21:0]);
  assign round_up = guard & (sticky | m24[0]);
  assign m25      = {1'b0, m24} + {24'd0, round_up};
  // A carry out of rounding leaves 1.000..0, so the fraction is the shifted-down sum.
  assign frac     = m25[24] ? m25[23:1] : m25[22:0];
  assign exp_f    = exp_n + {10'd0, m25[24]};
`else
  logic unused_trunc_bits;

  assign unused_trunc_bits = ^{m24[23], s2_p[22:0]};
  assign frac  = m24[22:0];
  assign exp_f = exp_n;
`endif

  always_comb begin
    res_num   = {s2_sign, exp_f[7:0], frac};
    res_flags = 2'b00;
    if (s2_zero) begin
      res_num   = {s2_sign, 31'b0};
      res_flags = 2'b00;
    end else if (exp_f <= 11'sd0) begin
      res_num   = {s2_sign, 31'b0};
      res_flags = 2'b01;
    end else if (exp_f >= 11'sd255) begin
      res_num   = {s2_sign, 8'hFE, 23'h7FFFFF};
      res_flags = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      NumOut    <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      NumOut    <= res_num;
      flags     <= res_flags;
    end
  end

endmodule

// File: tb/tb_newton_step_multiply.sv
// Directed self-checking bench for newton_step_multiply (honours NEWTON_MUL_ROUND_NEAREST_EN).
module tb_newton_step_multiply;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] NumA;
  logic [31:0] Init;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] NumOut;
  logic [1:0]  flags;

  int checks   = 0;
  int failures = 0;

  newton_step_multiply dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .NumA      (NumA),
    .Init      (Init),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .NumOut    (NumOut),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one pair, then confirm it surfaces exactly three edges later.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_num, input logic [1:0] exp_flags,
                            input string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    NumA      = a;
    Init      = b;
    out_ready = 1'b1;
    ce        = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_num"}, NumOut, exp_num);
    chk({tag, "_flags"}, {30'd0, flags}, {30'd0, exp_flags});
  endtask

  logic [31:0] ba   [5];
  logic [31:0] bb   [5];
  logic [31:0] bexp [5];
  logic [31:0] round_exp;

  initial begin
    rst       = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    NumA      = '0;
    Init      = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_numout", NumOut, 32'd0);
    chk("rst_flags", {30'd0, flags}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_single(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 2'b00, "basic");
    run_single(32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00, "norm_carry");
`ifdef NEWTON_MUL_ROUND_NEAREST_EN
    round_exp = 32'h3FC00002;
`else
    round_exp = 32'h3FC00001;
`endif
    run_single(32'h3F800001, 32'h3FC00000, round_exp, 2'b00, "rounding");
    run_single(32'h00800000, 32'h00800000, 32'h00000000, 2'b01, "underflow");
    run_single(32'h7F000000, 32'h40000000, 32'h7F7FFFFF, 2'b10, "overflow");
    run_single(32'h00000000, 32'h3FC00000, 32'h00000000, 2'b00, "zero_in");
    run_single(32'hBFC00000, 32'h3FC00000, 32'hC0100000, 2'b00, "neg_sign");

    ba[0] = 32'h3FC00000; bb[0] = 32'h3F800000; bexp[0] = 32'h3FC00000;
    ba[1] = 32'h3FC00000; bb[1] = 32'h3FC00000; bexp[1] = 32'h40100000;
    ba[2] = 32'h40000000; bb[2] = 32'h40000000; bexp[2] = 32'h40800000;
    ba[3] = 32'h3F800000; bb[3] = 32'h40400000; bexp[3] = 32'h40400000;
    ba[4] = 32'h3F000000; bb[4] = 32'h40000000; bexp[4] = 32'h3F800000;

    begin
      int sent = 0;
      int recv = 0;
      int t = 0;
      while (recv < 5 && t < 60) begin
        @(negedge clk);
        out_ready = (t < 3) || (t >= 10);
        ce        = !(t == 12 || t == 13);
        in_valid  = (sent < 5);
        if (sent < 5) begin
          NumA = ba[sent];
          Init = bb[sent];
        end
        #1;
        if (t == 3) chk("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
        if (t == 5 || t == 9) begin
          chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_hold_num", NumOut, bexp[0]);
        end
        if (t == 12 || t == 13) begin
          chk("ce_freeze_in_ready", {31'd0, in_ready}, 32'd0);
          chk("ce_freeze_valid", {31'd0, out_valid}, 32'd1);
          chk("ce_freeze_num", NumOut, bexp[recv]);
        end
        if (in_valid && in_ready) sent++;
        if (out_valid && out_ready && ce) begin
          chk("bp_order_num", NumOut, bexp[recv]);
          chk("bp_order_flags", {30'd0, flags}, 32'd0);
          recv++;
        end
        t++;
      end
      chk("bp_recv_count", recv, 32'd5);
      chk("bp_sent_count", sent, 32'd5);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    ce        = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp_no_duplicate", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      NumA     = ba[i];
      Init     = bb[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_num", NumOut, 32'd0);
    chk("async_rst_flags", {30'd0, flags}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("post_rst_idle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("post_rst_idle2", {31'd0, out_valid}, 32'd0);
    run_single(32'h40000000, 32'h40000000, 32'h40800000, 2'b00, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
